square_rotator_dir: RTL
=======================

// Module: square_rotator_dir
// PURPOSE
//  Bidirectional rotating-square driver for the 4-digit, active-low 7-segment display.
//  A square glyph walks around the display perimeter, one position per step:
//   - clockwise: top row left->right, then bottom row right->left.
//   - counterclockwise: the same path in reverse.
//  Adds a direction switch (synchronised in-block), a speed select and a one-cycle step strobe.
//  Sits between board switches/top level and the an/sseg display pins.
// PARAMETERS
//  STEP_CYCLES  2**25  enabled clk cycles per step at speed=0; must be a multiple of 8, >=8
//  CNT_W        28     prescaler width; must hold STEP_CYCLES-1
// PORTS
//  clk      in   1  system clock (50 MHz)
//  reset    in   1  asynchronous, active-high reset
//  en       in   1  synchronous run enable; low freezes prescaler and position
//  cw       in   1  direction switch, asynchronous: 1=clockwise, 0=counterclockwise
//  speed    in   2  synchronous step-rate select: period = STEP_CYCLES >> speed
//  an       out  4  digit enables, active low, exactly one low
//  sseg     out  8  segments {dp,a..g}, active low
//  pos      out  3  current perimeter position 0..7
//  step     out  1  one-cycle pulse in the cycle pos takes a new value
// BEHAVIOUR
//  Reset (async, immediate):
//   - cnt=0, pos=0, step=0; cw synchroniser flops=1 (clockwise).
//   - an=4'b0111, sseg=8'b10011100.
//  cw synchroniser: 2 flops, so cw reaches the direction logic 2 clk edges after it changes.
//  Prescaler:
//   - limit = STEP_CYCLES >> speed (speed 3 -> STEP_CYCLES/8).
//   - Terminal condition: cnt >= limit-1.
//   - Edge with en=1 and terminal: cnt<=0; pos<=next pos; step<=1.
//   - Edge with en=1, not terminal: cnt<=cnt+1; step<=0.
//   - Edge with en=0: cnt and pos hold; step<=0.
//  Speed change mid-count:
//   - If cnt >= limit-1 after the change, the very next enabled edge is terminal.
//   - No extra steps are produced and cnt never overruns.
//  Next pos (mod 8 wrap):
//   - synced cw=1: pos+1; 7->0.
//   - synced cw=0: pos-1; 0->7.
//   - Direction is the synced value at the terminal edge only; changes between steps never move pos.
//  Decode: an/sseg are a pure combinational decode of registered pos. No latency from pos; glitch-free.
//   pos  an    sseg        (top=8'b10011100, bottom=8'b11100010)
//   0    0111  top          4    1110  bottom
//   1    1011  top          5    1101  bottom
//   2    1101  top          6    1011  bottom
//   3    1110  top          7    0111  bottom
//  dp (sseg[7]) is always 1 (off).
//  Reset mid-step: all state returns to reset values at once. The first step after reset release
//   needs a full period of enabled cycles.
//  Simultaneous en=0 and terminal count: the hold wins. The step fires on the next enabled edge.
// TESTING (sim with STEP_CYCLES=16)
//  1) Release reset, en=1, cw=1, speed=0 -> step=1 for exactly 1 cycle after the 16th enabled edge.
//     pos=1, an=1011, sseg=10011100. After 8 steps pos=0, an=0111.
//  2) Reset with cw=0 held, en=1 -> first step pos=7, an=0111, sseg=11100010.
//     Second step pos=6, an=1011, sseg=11100010.
//  3) en=1 for 10 edges, en=0 for 50 edges, en=1 again -> step fires on the 6th re-enabled edge.
//     No step and no pos change while en=0.
//  4) speed=3 -> step every 2 enabled edges.
//     Change speed 0->3 when cnt=10 -> step on the next edge, then every 2 edges.
//  5) Toggle cw 1 edge before terminal -> step uses the old direction. The next step uses the new one.
//     Toggle >=2 edges before terminal -> the new direction applies at that step.
//  6) Assert reset when pos=5, cnt=9 -> without waiting for a clk edge, an=0111, sseg=10011100, step=0.
//     After release, first step at the 16th enabled edge.

Source files
------------

// File: rtl/square_rotator_dir.sv
// Rotating-square driver for a 4-digit active-low 7-segment display.
// The glyph walks the perimeter in either direction at a selectable step rate.
module square_rotator_dir #(
   parameter int STEP_CYCLES = 2**25,
   parameter int CNT_W       = 28
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       cw,
   input  logic [1:0] speed,
   output logic [3:0] an,
   output logic [7:0] sseg,
   output logic [2:0] pos,
   output logic       step
);

   localparam logic [CNT_W-1:0] STEP_FULL = CNT_W'(STEP_CYCLES);
   localparam logic [7:0]       SSEG_TOP  = 8'b10011100;
   localparam logic [7:0]       SSEG_BOT  = 8'b11100010;

   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] limit_m1;
   logic [2:0]       pos_reg, pos_next;
   logic             step_reg, step_next;
   logic             cw_meta_reg, cw_sync_reg;
   logic             terminal;
   logic [1:0]       digit;

   // Using >= rather than == keeps a mid-count speed increase from overrunning.
   assign limit_m1 = (STEP_FULL >> speed) - CNT_W'(1);
   assign terminal = (cnt_reg >= limit_m1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cw_meta_reg <= 1'b1;
         cw_sync_reg <= 1'b1;
      end else begin
         cw_meta_reg <= cw;
         cw_sync_reg <= cw_meta_reg;
      end
   end

   always_comb begin
      cnt_next  = cnt_reg;
      pos_next  = pos_reg;
      step_next = 1'b0;
      if (en) begin
         if (terminal) begin
            cnt_next  = '0;
            pos_next  = cw_sync_reg ? pos_reg + 3'd1 : pos_reg - 3'd1;
            step_next = 1'b1;
         end else begin
            cnt_next  = cnt_reg + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg  <= '0;
         pos_reg  <= 3'd0;
         step_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         pos_reg  <= pos_next;
         step_reg <= step_next;
      end
   end

   // Top row walks digits 3..0 left to right; bottom row walks them back 0..3.
   assign digit = pos_reg[2] ? pos_reg[1:0] : (2'd3 - pos_reg[1:0]);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_an
         assign an[gi] = (digit != 2'(gi));
      end
   endgenerate

   assign sseg = pos_reg[2] ? SSEG_BOT : SSEG_TOP;
   assign pos  = pos_reg;
   assign step = step_reg;

endmodule
